// File: rtl/shiftreg_deserializer_if.sv
// Handshake/data bundle between the serial-link deserializer and its consumer.
// The slave side is the deserializer; the master side drives serial bits and consumes words.
interface shiftreg_deserializer_if #(
  parameter int DATASIZE = 8
);
  logic                clear_i;
  logic                mode_i;
  logic                ser_i;
  logic                ser_valid_i;
  logic                ready_i;
  logic [DATASIZE-1:0] value_o;
  logic                valid_o;
  logic                busy_o;
  logic                overrun_o;
  logic                parity_err_o;

  modport slave (
    input  clear_i,
    input  mode_i,
    input  ser_i,
    input  ser_valid_i,
    input  ready_i,
    output value_o,
    output valid_o,
    output busy_o,
    output overrun_o,
    output parity_err_o
  );

  modport master (
    output clear_i,
    output mode_i,
    output ser_i,
    output ser_valid_i,
    output ready_i,
    input  value_o,
    input  valid_o,
    input  busy_o,
    input  overrun_o,
    input  parity_err_o
  );
endinterface

// File: rtl/shiftreg_deserializer.sv
// Serial-to-parallel receiver: strobed bits into DATASIZE-bit words, MSB- or LSB-first, one-entry valid/ready buffer.
// Optional even-parity bit per word when PARITY_SHIFTREG_DESER_EN is defined.
module shiftreg_deserializer #(
  parameter int DATASIZE = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  shiftreg_deserializer_if.slave bus
);

  localparam int CW = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATASIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATASIZE-1:0] r_sr;
  logic [DATASIZE-1:0] w_sr_nxt;
  logic [DATASIZE-1:0] w_sr_shift;
  logic [DATASIZE-1:0] w_word;
  logic [DATASIZE-1:0] r_value;
  logic [DATASIZE-1:0] w_value_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_ord;
  logic                w_ord_nxt;
  logic                w_ord_eff;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_overrun;
  logic                w_overrun_nxt;
  logic                w_complete;
`ifdef PARITY_SHIFTREG_DESER_EN
  logic                r_perr;
  logic                w_perr_nxt;
  logic                w_err;
`endif

  // Bit order is taken live from mode_i on the first bit, then frozen in r_ord.
  always_comb begin
    w_ord_eff  = (r_state == ST_DATA && r_cnt == '0) ? bus.mode_i : r_ord;
    w_sr_shift = w_ord_eff ? {bus.ser_i, r_sr[DATASIZE-1:1]}
                           : {r_sr[DATASIZE-2:0], bus.ser_i};
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_ord_nxt     = r_ord;
    w_busy_nxt    = r_busy;
    w_overrun_nxt = r_overrun;
    w_value_nxt   = r_value;
    w_valid_nxt   = r_valid;
    w_complete    = 1'b0;
    w_word        = w_sr_shift;
`ifdef PARITY_SHIFTREG_DESER_EN
    w_err         = (^r_sr) ^ bus.ser_i;
    w_perr_nxt    = r_perr;
`endif

    if (bus.clear_i) begin
      w_cnt_nxt     = '0;
      w_state_nxt   = ST_DATA;
      w_busy_nxt    = 1'b0;
      w_overrun_nxt = 1'b0;
`ifdef PARITY_SHIFTREG_DESER_EN
      w_perr_nxt    = 1'b0;
`endif
    end else if (bus.ser_valid_i) begin
      case (r_state)
        ST_DATA: begin
          w_ord_nxt  = w_ord_eff;
          w_sr_nxt   = w_sr_shift;
          w_busy_nxt = 1'b1;
          if (r_cnt == LAST) begin
            w_cnt_nxt = '0;
`ifdef PARITY_SHIFTREG_DESER_EN
            w_state_nxt = ST_PARITY;
`else
            w_complete = 1'b1;
            w_busy_nxt = 1'b0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
        end
        ST_PARITY: begin
          w_word      = r_sr;
          w_complete  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_DATA;
        end
      endcase
    end

    // A consume on the completion edge frees the slot, so the new word replaces the old one.
    if (w_complete) begin
      if (!r_valid || bus.ready_i) begin
        w_value_nxt = w_word;
        w_valid_nxt = 1'b1;
`ifdef PARITY_SHIFTREG_DESER_EN
        w_perr_nxt  = w_err;
`endif
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else if (r_valid && bus.ready_i) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_DATA;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_ord     <= 1'b0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef PARITY_SHIFTREG_DESER_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ord     <= w_ord_nxt;
      r_value   <= w_value_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_overrun <= w_overrun_nxt;
`ifdef PARITY_SHIFTREG_DESER_EN
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  assign bus.value_o   = r_value;
  assign bus.valid_o   = r_valid;
  assign bus.busy_o    = r_busy;
  assign bus.overrun_o = r_overrun;
`ifdef PARITY_SHIFTREG_DESER_EN
  assign bus.parity_err_o = r_perr;
`else
  assign bus.parity_err_o = 1'b0;
`endif

endmodule

// File: doc/shiftreg_deserializer.md
# shiftreg_deserializer

Serial-to-parallel receiver for the shift-register serial link. It gathers a stream of strobed serial bits into DATASIZE-bit words, MSB-first or LSB-first. Each completed word goes to a one-entry output buffer with a valid/ready handshake. It sits on the receive end of the link, opposite the parallel-load/shift transmitter, and feeds words to the downstream consumer.

## Interface
- DATASIZE, 8, word width in bits; legal range DATASIZE >= 2
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  synchronous abort of the partial word; clears overrun_o and parity_err_o
- mode_i  in  1  bit order: 0 = MSB first (shift left, insert at LSB); 1 = LSB first (shift right, insert at MSB)
- ser_i  in  1  serial data bit
- ser_valid_i  in  1  ser_i is sampled on this cycle's edge
- value_o  out  DATASIZE  buffered received word
- valid_o  out  1  value_o holds an unconsumed word
- ready_i  in  1  consumer accepts value_o when valid_o && ready_i
- busy_o  out  1  partial word in progress (bit count != 0 or parity pending)
- overrun_o  out  1  sticky: a completed word was dropped
- parity_err_o  out  1  only with PARITY_EN: parity error on the word currently in value_o

## Operation
- Internal state:
  - shift register sr (DATASIZE bits)
  - bit counter cnt (0..DATASIZE-1, width $clog2(DATASIZE))
  - latched order bit ord
  - FSM state: DATA, or PARITY (PARITY only with PARITY_EN)
- Priority per edge: rst_i, then clear_i, then ser_valid_i.
- Reset values:
  - value_o = 0, valid_o = 0, busy_o = 0, overrun_o = 0, parity_err_o = 0
  - sr = 0, cnt = 0, state = DATA
- clear_i:
  - Sets cnt = 0 and state = DATA, and clears overrun_o and parity_err_o.
  - value_o and valid_o are unchanged.
  - ser_valid_i is ignored on a clear_i cycle.
- DATA state, on ser_valid_i:
  - When cnt == 0, ord is loaded from mode_i. mode_i is ignored for the rest of the word.
  - ord = 0: sr <= {sr[DATASIZE-2:0], ser_i}. ord = 1: sr <= {ser_i, sr[DATASIZE-1:1]}.
  - ord for the first bit is taken from mode_i on that same cycle.
  - cnt increments by 1. On the last bit (cnt == DATASIZE-1), cnt wraps to 0 and the word completes.
  - With PARITY_EN, the word does not complete yet; the FSM goes to PARITY instead.
- PARITY state (PARITY_EN only):
  - The next ser_valid_i bit is the even-parity bit.
  - err = ^sr ^ ser_i.
  - The word completes with err, and the FSM returns to DATA.
- Word completion (word W = sr including the final shifted bit):
  - valid_o == 0 or ready_i == 1: value_o <= W and valid_o <= 1. With PARITY_EN, parity_err_o <= err.
  - valid_o == 1 and ready_i == 0: W is dropped and overrun_o <= 1. value_o and parity_err_o are kept.
- Handshake:
  - When valid_o && ready_i and no completion on the same edge, valid_o <= 0.
  - value_o is stable while valid_o && !ready_i.
- Gaps (ser_valid_i = 0) hold all state indefinitely.

## Timing
- Latency: the final bit (or the parity bit) is sampled at edge N; value_o and valid_o are updated at edge N. The word is visible from cycle N+1.
- Back-to-back words with ser_valid_i held high are supported at full rate: one bit per clock, with no dead cycle between words.
- busy_o is registered. It is 1 from the edge after the first bit until the completion edge.
- A consume and a completion on the same edge replace value_o with no valid_o gap and no overrun.
- rst_i mid-word discards the partial word and the buffer; all outputs take their reset values on the next cycle.

## Configuration
- PARITY_SHIFTREG_DESER_EN defined:
  - Each word is followed by one even-parity bit (the PARITY state).
  - parity_err_o is driven as above.
  - Frame length is DATASIZE+1 bits.
- Macro undefined:
  - No PARITY state; frame length is DATASIZE bits.
  - parity_err_o is tied to 0. The port remains so the interface stays fixed.

## Test plan
- Bit order, MSB first:
  - Stimulus: DATASIZE=8, mode_i=0, ready_i=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - Response: value_o=0xB2 and valid_o=1 in the cycle after the 8th bit.
- Bit order, LSB first:
  - Stimulus: same bits with mode_i=1.
  - Response: value_o=0x4D.
  - Also: toggle mode_i mid-word; the result must be unchanged.
- Overrun:
  - Stimulus: ready_i=0, words 0xA5 then 0x3C.
  - Response: value_o stays 0xA5 and overrun_o=1 after the 16th bit.
  - Then: ready_i=1 for one cycle gives valid_o=0; clear_i gives overrun_o=0.
- Simultaneous consume and complete:
  - Stimulus: 0xA5 buffered, ready_i=1 exactly on the completion edge of 0x3C.
  - Response: value_o=0x3C, valid_o stays 1, overrun_o=0.
- Abort, reset and gaps:
  - clear_i after 5 bits, then 0xFF: value_o=0xFF, and busy_o=0 right after the clear.
  - rst_i after 3 bits: all outputs 0.
  - ser_valid_i with random gaps: the word is unchanged.
- Parity (PARITY_SHIFTREG_DESER_EN defined):
  - 0x03 + parity 0: parity_err_o=0.
  - 0x03 + parity 1: parity_err_o=1, and value_o=0x03 is still delivered.
  - 9-bit frames back-to-back: no dead cycle between words.
